// File: rtl/simd_pkg.sv
// Shared types and constants for the SIMD PE sequencer.
// Contents:
//   op_e         PE operation encoding (the sequencer forwards cmd_op unchanged as pe_mode)
//   seq_state_e  sequencer FSM states
//   PE_LATENCY, MEM_RD_LATENCY, PIPE_DEPTH  fixed pipeline latencies
//   beat_t       one vector-memory beat at the default geometry
package simd_pkg;

  typedef enum logic [1:0] {
    OP_MUL = 2'b00,
    OP_SUB = 2'b01,
    OP_ADD = 2'b10
  } op_e;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StDrain = 2'b10,
    StDone  = 2'b11
  } seq_state_e;

  localparam int unsigned PE_LATENCY     = 1;
  localparam int unsigned MEM_RD_LATENCY = 1;
  // In-flight tracking depth: read issue -> operand -> result.
  localparam int unsigned PIPE_DEPTH     = MEM_RD_LATENCY + PE_LATENCY;

  localparam int unsigned DEF_LANES  = 4;
  localparam int unsigned DEF_DATA_W = 32;

  typedef logic [DEF_LANES*DEF_DATA_W-1:0] beat_t;

endpackage

// File: rtl/simd_pe_sequencer_if.sv
// Bus bundle between the sequencer, the instruction decoder, the dual-read
// vector memory and the PE array.
// Signal groups:
//   cmd_*          command handshake and fields from the decoder
//   rd_*           read strobe/addresses to the memory, read data back
//   pe_a/pe_b/pe_mode/pe_res  PE operands, shared mode, PE results
//   wr_*           result write-back to the memory
// Modports:
//   master  the sequencer (drives memory/PE controls, accepts commands)
//   slave   the surrounding decoder, memory and PE array
interface simd_pe_sequencer_if #(
  parameter int unsigned LANES  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned LEN_W  = 8
);

  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [1:0]                cmd_op;
  logic [ADDR_W-1:0]         cmd_src_a;
  logic [ADDR_W-1:0]         cmd_src_b;
  logic [ADDR_W-1:0]         cmd_dst;
  logic [LEN_W-1:0]          cmd_len;

  logic                      rd_en;
  logic [ADDR_W-1:0]         rd_addr_a;
  logic [ADDR_W-1:0]         rd_addr_b;
  logic [LANES*DATA_W-1:0]   rd_data_a;
  logic [LANES*DATA_W-1:0]   rd_data_b;

  logic [LANES*DATA_W-1:0]   pe_a;
  logic [LANES*DATA_W-1:0]   pe_b;
  logic [1:0]                pe_mode;
  logic [LANES*DATA_W-1:0]   pe_res;

  logic                      wr_en;
  logic [ADDR_W-1:0]         wr_addr;
  logic [LANES*DATA_W-1:0]   wr_data;

  modport master (
    input  cmd_valid, cmd_op, cmd_src_a, cmd_src_b, cmd_dst, cmd_len,
    input  rd_data_a, rd_data_b, pe_res,
    output cmd_ready, rd_en, rd_addr_a, rd_addr_b,
    output pe_a, pe_b, pe_mode, wr_en, wr_addr, wr_data
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_src_a, cmd_src_b, cmd_dst, cmd_len,
    output rd_data_a, rd_data_b, pe_res,
    input  cmd_ready, rd_en, rd_addr_a, rd_addr_b,
    input  pe_a, pe_b, pe_mode, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/simd_pe_seq_pipe.sv
// In-flight beat tracker: a valid/address shift register that follows each
// issued read through memory and PE latency so the write strobe and address
// line up with the PE result.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (drops in-flight beats)
//   in_valid     a read beat is issued this cycle
//   in_addr      destination address for that beat
//   feed_valid   some beat is still in a stage before the output stage
//   out_valid    beat result is on pe_res this cycle (write strobe)
//   out_addr     destination address of that beat
module simd_pe_seq_pipe #(
  parameter int unsigned DEPTH  = 2,  // must be >= 2
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              feed_valid,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr
);

  logic [DEPTH-1:0]  valid_q;
  logic [ADDR_W-1:0] addr_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
      end
    end else begin
      valid_q   <= {valid_q[DEPTH-2:0], in_valid};
      addr_q[0] <= in_addr;
      for (int i = 1; i < DEPTH; i++) begin
        addr_q[i] <= addr_q[i-1];
      end
    end
  end

  assign feed_valid = |valid_q[DEPTH-2:0];
  assign out_valid  = valid_q[DEPTH-1];
  assign out_addr   = addr_q[DEPTH-1];

endmodule

// File: rtl/simd_pe_sequencer.sv
// Sequences one vector instruction across LANES PE lanes: accepts a command,
// streams operand reads from the dual-read vector memory into the PEs and
// writes the results to the destination vector. pe_mode is held from the
// cycle after accept until the last write; the DRAIN/DONE bubble keeps
// instructions with different modes from overlapping in the PE.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          command / memory / PE bundle (master side)
//   busy         state is not IDLE
//   done         one-cycle completion pulse
//   perf_busy_cycles, perf_instr_count   saturating counters, present only
//                when SIMD_PE_SEQ_PERF_EN is defined
module simd_pe_sequencer
  import simd_pkg::*;
#(
  parameter int unsigned LANES  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned LEN_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  simd_pe_sequencer_if.master bus,
  output logic                busy,
  output logic                done
`ifdef SIMD_PE_SEQ_PERF_EN
  ,
  output logic [31:0]         perf_busy_cycles,
  output logic [31:0]         perf_instr_count
`endif
);

  localparam int unsigned BEAT_W = LANES * DATA_W;

  seq_state_e        state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_a_q, rd_addr_a_d;
  logic [ADDR_W-1:0] rd_addr_b_q, rd_addr_b_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [LEN_W-1:0]  remain_q, remain_d;  // beats left after the current one

  logic              pipe_feed_valid;
  logic              pipe_out_valid;
  logic [ADDR_W-1:0] pipe_out_addr;

  logic [BEAT_W-1:0] opnd_a, opnd_b, result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_a_q <= '0;
      rd_addr_b_q <= '0;
      wr_ptr_q    <= '0;
      remain_q    <= '0;
    end else begin
      mode_q      <= mode_d;
      rd_en_q     <= rd_en_d;
      rd_addr_a_q <= rd_addr_a_d;
      rd_addr_b_q <= rd_addr_b_d;
      wr_ptr_q    <= wr_ptr_d;
      remain_q    <= remain_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    rd_en_d     = 1'b0;
    rd_addr_a_d = rd_addr_a_q;
    rd_addr_b_d = rd_addr_b_q;
    wr_ptr_d    = wr_ptr_q;
    remain_d    = remain_q;

    unique case (state_q)
      StIdle: begin
        if (bus.cmd_valid) begin
          mode_d      = bus.cmd_op;
          rd_addr_a_d = bus.cmd_src_a;
          rd_addr_b_d = bus.cmd_src_b;
          wr_ptr_d    = bus.cmd_dst;
          remain_d    = bus.cmd_len - LEN_W'(1);
          if (bus.cmd_len != '0) begin
            rd_en_d = 1'b1;
            state_d = StRun;
          end else begin
            state_d = StDone;
          end
        end
      end
      StRun: begin
        // wr_ptr_q travels with the beat read this cycle.
        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        if (remain_q == '0) begin
          state_d = StDrain;
        end else begin
          rd_en_d     = 1'b1;
          remain_d    = remain_q - LEN_W'(1);
          rd_addr_a_d = rd_addr_a_q + ADDR_W'(1);
          rd_addr_b_d = rd_addr_b_q + ADDR_W'(1);
        end
      end
      StDrain: begin
        // Once only the output stage holds a beat, this cycle is the last write.
        if (!pipe_feed_valid) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  simd_pe_seq_pipe #(
    .DEPTH  (PIPE_DEPTH),
    .ADDR_W (ADDR_W)
  ) u_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (rd_en_q),
    .in_addr    (wr_ptr_q),
    .feed_valid (pipe_feed_valid),
    .out_valid  (pipe_out_valid),
    .out_addr   (pipe_out_addr)
  );

  assign opnd_a = bus.rd_data_a;
  assign opnd_b = bus.rd_data_b;
  assign result = bus.pe_res;

  assign bus.cmd_ready = (state_q == StIdle);
  assign bus.rd_en     = rd_en_q;
  assign bus.rd_addr_a = rd_addr_a_q;
  assign bus.rd_addr_b = rd_addr_b_q;
  assign bus.pe_a      = opnd_a;
  assign bus.pe_b      = opnd_b;
  assign bus.pe_mode   = mode_q;
  assign bus.wr_en     = pipe_out_valid;
  assign bus.wr_addr   = pipe_out_addr;
  assign bus.wr_data   = result;

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);

`ifdef SIMD_PE_SEQ_PERF_EN
  logic [31:0] perf_busy_q, perf_instr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_busy_q  <= '0;
      perf_instr_q <= '0;
    end else begin
      if (busy && (perf_busy_q != '1)) begin
        perf_busy_q <= perf_busy_q + 32'd1;
      end
      if (done && (perf_instr_q != '1)) begin
        perf_instr_q <= perf_instr_q + 32'd1;
      end
    end
  end

  assign perf_busy_cycles = perf_busy_q;
  assign perf_instr_count = perf_instr_q;
`endif

endmodule

// File: tb/tb_simd_pe_sequencer.sv
`timescale 1ns/1ps
module tb_simd_pe_sequencer;
  import simd_pkg::*;

  localparam int LANES  = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;
  localparam int LEN_W  = 8;
  localparam int BW     = LANES * DATA_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, done;
`ifdef SIMD_PE_SEQ_PERF_EN
  logic [31:0] perf_busy_cycles, perf_instr_count;
`endif

  simd_pe_sequencer_if #(.LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

  simd_pe_sequencer #(
    .LANES  (LANES),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy),
    .done  (done)
`ifdef SIMD_PE_SEQ_PERF_EN
    ,
    .perf_busy_cycles (perf_busy_cycles),
    .perf_instr_count (perf_instr_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Vector memory (preloaded by the bench only) and PE array models.
  logic [BW-1:0] mem [256];

  function automatic logic [BW-1:0] pe_calc(input logic [1:0] m, input logic [BW-1:0] a,
                                            input logic [BW-1:0] b);
    logic [BW-1:0] r;
    logic [DATA_W-1:0] x, y;
    r = '0;
    for (int l = 0; l < LANES; l++) begin
      x = a[l*DATA_W +: DATA_W];
      y = b[l*DATA_W +: DATA_W];
      case (m)
        2'b00:   r[l*DATA_W +: DATA_W] = x * y;
        2'b01:   r[l*DATA_W +: DATA_W] = x - y;
        default: r[l*DATA_W +: DATA_W] = x + y;
      endcase
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (bus.rd_en) begin
      bus.rd_data_a <= mem[bus.rd_addr_a];
      bus.rd_data_b <= mem[bus.rd_addr_b];
    end
    bus.pe_res <= pe_calc(bus.pe_mode, bus.pe_a, bus.pe_b);
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard of expected writes.
  logic [ADDR_W-1:0] exp_addr_q [$];
  logic [BW-1:0]     exp_data_q [$];
  logic [1:0]        exp_mode_q [$];

  // Observation logs.
  int                rd_cyc [$];
  logic [ADDR_W-1:0] rd_a_l [$];
  int                wr_cyc [$];
  logic [ADDR_W-1:0] wr_addr_l [$];
  logic [BW-1:0]     wr_data_l [$];
  logic [1:0]        wr_mode_l [$];
  int                done_cyc;
  int                ready_seen;

  function automatic int q_first(input int q[$]);
    return (q.size() > 0) ? q[0] : -1;
  endfunction

  function automatic int q_last(input int q[$]);
    return (q.size() > 0) ? q[q.size()-1] : -1;
  endfunction

  task automatic clear_logs();
    rd_cyc.delete(); rd_a_l.delete(); wr_cyc.delete(); wr_addr_l.delete();
    wr_data_l.delete(); wr_mode_l.delete();
    exp_addr_q.delete(); exp_data_q.delete(); exp_mode_q.delete();
    done_cyc = -1; ready_seen = 0;
  endtask

  task automatic push_exp(input logic [1:0] op, input logic [7:0] sa, input logic [7:0] sb,
                          input logic [7:0] d, input int len);
    for (int k = 0; k < len; k++) begin
      exp_addr_q.push_back(d + 8'(k));
      exp_data_q.push_back(pe_calc(op, mem[sa + 8'(k)], mem[sb + 8'(k)]));
      exp_mode_q.push_back(op);
    end
  endtask

  // Drive a command; t returns the cycle in which it was accepted.
  task automatic issue(input logic [1:0] op, input logic [7:0] sa, input logic [7:0] sb,
                       input logic [7:0] d, input logic [7:0] len, input bit hold,
                       output int t);
    bit acc;
    acc = 1'b0;
    t = -1;
    @(posedge clk); #1;
    bus.cmd_op = op; bus.cmd_src_a = sa; bus.cmd_src_b = sb; bus.cmd_dst = d;
    bus.cmd_len = len; bus.cmd_valid = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        acc = 1'b1;
        t = cyc;
      end
    end
    n_checks++;
    if (!acc) begin
      n_fail++;
      $display("FAIL accept_timeout: cmd_ready=%b, required 1 within 50 cycles", bus.cmd_ready);
    end
    @(posedge clk); #1;
    if (!hold) bus.cmd_valid = 1'b0;
  endtask

  // Log DUT activity each cycle until done pulses (bounded).
  task automatic observe(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (bus.rd_en) begin rd_cyc.push_back(cyc); rd_a_l.push_back(bus.rd_addr_a); end
      if (bus.wr_en) begin
        wr_cyc.push_back(cyc); wr_addr_l.push_back(bus.wr_addr);
        wr_data_l.push_back(bus.wr_data); wr_mode_l.push_back(bus.pe_mode);
      end
      if (bus.cmd_ready) ready_seen++;
      if (done) begin done_cyc = cyc; seen = 1'b1; end
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL done_timeout: done=%b, required a done pulse within %0d cycles", done, budget);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.rd_en, bus.wr_en, busy, done, bus.pe_mode, bus.rd_addr_a, bus.rd_addr_b,
         bus.wr_addr} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: rd_en=%b wr_en=%b busy=%b done=%b mode=%b ra=%h rb=%h wa=%h, required all 0",
               bus.rd_en, bus.wr_en, busy, done, bus.pe_mode, bus.rd_addr_a, bus.rd_addr_b, bus.wr_addr);
    end
    n_checks++;
    if (bus.cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b required 1", bus.cmd_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: ready=%b busy=%b, required 1/0", bus.cmd_ready, busy);
    end
  endtask

  task automatic test_add();
    int t;
    logic [ADDR_W-1:0] ea;
    logic [BW-1:0] ed;
    logic [1:0] em;
    clear_logs();
    push_exp(OP_ADD, 8'h10, 8'h20, 8'h30, 3);
    issue(OP_ADD, 8'h10, 8'h20, 8'h30, 8'd3, 1'b0, t);
    observe(40);
    n_checks++;
    if (rd_cyc.size() != 3 || q_first(rd_cyc) != t + 1 || q_last(rd_cyc) != t + 3) begin
      n_fail++;
      $display("FAIL add_rd_window: got %0d reads at +%0d..+%0d, required 3 at +1..+3",
               rd_cyc.size(), q_first(rd_cyc) - t, q_last(rd_cyc) - t);
    end
    n_checks++;
    if (q_first(wr_cyc) != t + 3 || q_last(wr_cyc) != t + 5) begin
      n_fail++;
      $display("FAIL add_wr_window: got +%0d..+%0d, required +3..+5",
               q_first(wr_cyc) - t, q_last(wr_cyc) - t);
    end
    n_checks++;
    if (done_cyc != t + 6) begin
      n_fail++;
      $display("FAIL add_done_time: got +%0d required +6", done_cyc - t);
    end
    n_checks++;
    if (bus.pe_mode !== 2'b10) begin
      n_fail++;
      $display("FAIL add_mode_at_done: got %b required 10", bus.pe_mode);
    end
    n_checks++;
    if (wr_addr_l.size() != exp_addr_q.size()) begin
      n_fail++;
      $display("FAIL add_wr_count: got %0d required %0d", wr_addr_l.size(), exp_addr_q.size());
    end
    while (wr_addr_l.size() > 0 && exp_addr_q.size() > 0) begin
      ea = exp_addr_q.pop_front(); ed = exp_data_q.pop_front(); em = exp_mode_q.pop_front();
      n_checks++;
      if (wr_addr_l[0] !== ea || wr_data_l[0] !== ed || wr_mode_l[0] !== em) begin
        n_fail++;
        $display("FAIL add_wr: got addr %h data %h mode %b, required addr %h data %h mode %b",
                 wr_addr_l[0], wr_data_l[0], wr_mode_l[0], ea, ed, em);
      end
      void'(wr_addr_l.pop_front()); void'(wr_data_l.pop_front()); void'(wr_mode_l.pop_front());
    end
  endtask

  task automatic test_back_to_back();
    int t1, t2;
    logic [ADDR_W-1:0] ea;
    logic [BW-1:0] ed;
    logic [1:0] em;
    clear_logs();
    mem[8'h40] = {4{32'd7}}; mem[8'h41] = {4{32'd7}};
    mem[8'h50] = {4{32'd3}}; mem[8'h51] = {4{32'd3}};
    mem[8'h60] = {4{32'd5}}; mem[8'h61] = {4{32'd5}};
    mem[8'h70] = {4{32'd6}}; mem[8'h71] = {4{32'd6}};
    for (int k = 0; k < 2; k++) begin
      exp_addr_q.push_back(8'hA0 + 8'(k)); exp_data_q.push_back({4{32'd4}});
      exp_mode_q.push_back(2'b01);
    end
    for (int k = 0; k < 2; k++) begin
      exp_addr_q.push_back(8'hB0 + 8'(k)); exp_data_q.push_back({4{32'd30}});
      exp_mode_q.push_back(2'b00);
    end
    issue(OP_SUB, 8'h40, 8'h50, 8'hA0, 8'd2, 1'b1, t1);
    bus.cmd_op = OP_MUL; bus.cmd_src_a = 8'h60; bus.cmd_src_b = 8'h70; bus.cmd_dst = 8'hB0;
    bus.cmd_len = 8'd2;
    observe(40);
    n_checks++;
    if (ready_seen != 0) begin
      n_fail++;
      $display("FAIL b2b_ready_while_busy: got %0d ready cycles, required 0", ready_seen);
    end
    n_checks++;
    if (bus.pe_mode !== 2'b01) begin
      n_fail++;
      $display("FAIL b2b_mode_held: got %b at first done, required 01", bus.pe_mode);
    end
    @(negedge clk);
    t2 = cyc;
    n_checks++;
    if (bus.cmd_ready !== 1'b1 || t2 != done_cyc + 1) begin
      n_fail++;
      $display("FAIL b2b_second_accept: ready=%b at +%0d after done, required 1 at +1",
               bus.cmd_ready, t2 - done_cyc);
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    observe(40);
    n_checks++;
    if (done_cyc != t2 + 5) begin
      n_fail++;
      $display("FAIL b2b_done2_time: got +%0d required +5", done_cyc - t2);
    end
    n_checks++;
    if (wr_addr_l.size() != exp_addr_q.size()) begin
      n_fail++;
      $display("FAIL b2b_wr_count: got %0d required %0d", wr_addr_l.size(), exp_addr_q.size());
    end
    while (wr_addr_l.size() > 0 && exp_addr_q.size() > 0) begin
      ea = exp_addr_q.pop_front(); ed = exp_data_q.pop_front(); em = exp_mode_q.pop_front();
      n_checks++;
      if (wr_addr_l[0] !== ea || wr_data_l[0] !== ed || wr_mode_l[0] !== em) begin
        n_fail++;
        $display("FAIL b2b_wr: got addr %h data %h mode %b, required addr %h data %h mode %b",
                 wr_addr_l[0], wr_data_l[0], wr_mode_l[0], ea, ed, em);
      end
      void'(wr_addr_l.pop_front()); void'(wr_data_l.pop_front()); void'(wr_mode_l.pop_front());
    end
  endtask

  task automatic test_len0();
    int t;
    clear_logs();
    issue(OP_MUL, 8'h00, 8'h00, 8'h33, 8'd0, 1'b0, t);
    observe(10);
    n_checks++;
    if (done_cyc != t + 1) begin
      n_fail++;
      $display("FAIL len0_done_time: got +%0d required +1", done_cyc - t);
    end
    n_checks++;
    if (rd_cyc.size() != 0 || wr_cyc.size() != 0) begin
      n_fail++;
      $display("FAIL len0_no_traffic: got %0d reads %0d writes, required 0/0",
               rd_cyc.size(), wr_cyc.size());
    end
    @(negedge clk);
    n_checks++;
    if (bus.cmd_ready !== 1'b1 || cyc != t + 2) begin
      n_fail++;
      $display("FAIL len0_ready_back: ready=%b at +%0d, required 1 at +2", bus.cmd_ready, cyc - t);
    end
  endtask

  task automatic test_wrap();
    int t;
    logic [ADDR_W-1:0] ea;
    logic [BW-1:0] ed;
    logic [1:0] em;
    logic [ADDR_W-1:0] exp_ra [3];
    exp_ra = '{8'hFE, 8'hFF, 8'h00};
    clear_logs();
    push_exp(OP_SUB, 8'hFE, 8'h80, 8'hFF, 3);
    issue(OP_SUB, 8'hFE, 8'h80, 8'hFF, 8'd3, 1'b0, t);
    observe(40);
    n_checks++;
    if (rd_a_l.size() != 3) begin
      n_fail++;
      $display("FAIL wrap_rd_count: got %0d required 3", rd_a_l.size());
    end
    for (int k = 0; k < 3 && k < rd_a_l.size(); k++) begin
      n_checks++;
      if (rd_a_l[k] !== exp_ra[k]) begin
        n_fail++;
        $display("FAIL wrap_rd_addr_a[%0d]: got %h required %h", k, rd_a_l[k], exp_ra[k]);
      end
    end
    n_checks++;
    if (wr_addr_l.size() != exp_addr_q.size()) begin
      n_fail++;
      $display("FAIL wrap_wr_count: got %0d required %0d", wr_addr_l.size(), exp_addr_q.size());
    end
    while (wr_addr_l.size() > 0 && exp_addr_q.size() > 0) begin
      ea = exp_addr_q.pop_front(); ed = exp_data_q.pop_front(); em = exp_mode_q.pop_front();
      n_checks++;
      if (wr_addr_l[0] !== ea || wr_data_l[0] !== ed || wr_mode_l[0] !== em) begin
        n_fail++;
        $display("FAIL wrap_wr: got addr %h data %h mode %b, required addr %h data %h mode %b",
                 wr_addr_l[0], wr_data_l[0], wr_mode_l[0], ea, ed, em);
      end
      void'(wr_addr_l.pop_front()); void'(wr_data_l.pop_front()); void'(wr_mode_l.pop_front());
    end
  endtask

  task automatic test_reset_mid();
    int t;
    int stray;
    logic [ADDR_W-1:0] ea;
    logic [BW-1:0] ed;
    logic [1:0] em;
    clear_logs();
    issue(OP_ADD, 8'h10, 8'h20, 8'h90, 8'd8, 1'b0, t);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.rd_en, bus.wr_en, busy, done, bus.pe_mode, bus.rd_addr_a, bus.wr_addr} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: rd_en=%b wr_en=%b busy=%b done=%b mode=%b ra=%h wa=%h, required all 0",
               bus.rd_en, bus.wr_en, busy, done, bus.pe_mode, bus.rd_addr_a, bus.wr_addr);
    end
    n_checks++;
    if (bus.cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_ready: got %b required 1", bus.cmd_ready);
    end
    stray = 0;
    repeat (3) begin @(negedge clk); if (bus.wr_en || bus.rd_en) stray++; end
    rst_n = 1'b1;
    repeat (6) begin @(negedge clk); if (bus.wr_en || bus.rd_en) stray++; end
    n_checks++;
    if (stray != 0 || bus.cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_quiet: got %0d strobe cycles ready=%b, required 0 and 1",
               stray, bus.cmd_ready);
    end
    clear_logs();
    push_exp(OP_ADD, 8'h05, 8'h06, 8'hC0, 2);
    issue(OP_ADD, 8'h05, 8'h06, 8'hC0, 8'd2, 1'b0, t);
    observe(40);
    n_checks++;
    if (wr_addr_l.size() != exp_addr_q.size()) begin
      n_fail++;
      $display("FAIL recover_wr_count: got %0d required %0d", wr_addr_l.size(), exp_addr_q.size());
    end
    while (wr_addr_l.size() > 0 && exp_addr_q.size() > 0) begin
      ea = exp_addr_q.pop_front(); ed = exp_data_q.pop_front(); em = exp_mode_q.pop_front();
      n_checks++;
      if (wr_addr_l[0] !== ea || wr_data_l[0] !== ed || wr_mode_l[0] !== em) begin
        n_fail++;
        $display("FAIL recover_wr: got addr %h data %h mode %b, required addr %h data %h mode %b",
                 wr_addr_l[0], wr_data_l[0], wr_mode_l[0], ea, ed, em);
      end
      void'(wr_addr_l.pop_front()); void'(wr_data_l.pop_front()); void'(wr_mode_l.pop_front());
    end
  endtask

`ifdef SIMD_PE_SEQ_PERF_EN
  task automatic test_perf();
    int t;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (perf_busy_cycles !== 32'd0 || perf_instr_count !== 32'd0) begin
      n_fail++;
      $display("FAIL perf_reset: got busy=%0d instr=%0d, required 0/0",
               perf_busy_cycles, perf_instr_count);
    end
    clear_logs();
    issue(OP_ADD, 8'h10, 8'h20, 8'hD0, 8'd4, 1'b0, t);
    observe(40);
    issue(OP_MUL, 8'h30, 8'h40, 8'hE0, 8'd4, 1'b0, t);
    observe(40);
    @(negedge clk);
    n_checks++;
    if (perf_instr_count !== 32'd2) begin
      n_fail++;
      $display("FAIL perf_instr_count: got %0d required 2", perf_instr_count);
    end
    n_checks++;
    if (perf_busy_cycles !== 32'd14) begin
      n_fail++;
      $display("FAIL perf_busy_cycles: got %0d required 14", perf_busy_cycles);
    end
  endtask
`endif

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_src_a = '0;
    bus.cmd_src_b = '0;
    bus.cmd_dst   = '0;
    bus.cmd_len   = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
    end
    test_reset();
    test_add();
    test_back_to_back();
    test_len0();
    test_wrap();
    test_reset_mid();
`ifdef SIMD_PE_SEQ_PERF_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
